// File: rtl/cla_add_scheduler.sv
// cla_add_scheduler: two-requester round-robin front end for a 16-bit
// adder that resolves one 4-bit carry-lookahead nibble per cycle.
module cla_add_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic        cin0,
  input  logic        cin1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy,
  output logic [15:0] sum,
  output logic        cout,
  output logic        done,
  output logic        done_id
);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t      state;
  logic [1:0]  k;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [15:0] acc;
  logic        carry;
  logic        owner;
  logic        prio;
  logic        pick1;
  logic        idle;
  logic [3:0]  na;
  logic [3:0]  nb;
  logic [3:0]  g;
  logic [3:0]  p;
  logic [3:0]  s;
  logic [4:0]  c;

  // prio=1 means requester 1 wins the next tie
  assign idle  = (state == IDLE);
  assign pick1 = (req0 & req1) ? prio : req1;
  assign gnt0  = rst_n & idle & req0 & ~pick1;
  assign gnt1  = rst_n & idle & req1 & pick1;
  assign busy  = ~idle;

  always_comb begin
    na = a_r[{k, 2'b00} +: 4];
    nb = b_r[{k, 2'b00} +: 4];
    g  = na & nb;
    p  = na ^ nb;
    c[0] = carry;
    c[1] = g[0]
         | (p[0] & c[0]);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & c[0]);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s = p ^ c[3:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= 2'd0;
      a_r     <= 16'h0000;
      b_r     <= 16'h0000;
      acc     <= 16'h0000;
      carry   <= 1'b0;
      owner   <= 1'b0;
      prio    <= 1'b0;
      sum     <= 16'h0000;
      cout    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt0 | gnt1) begin
            a_r   <= gnt1 ? a1 : a0;
            b_r   <= gnt1 ? b1 : b0;
            carry <= gnt1 ? cin1 : cin0;
            owner <= gnt1;
            prio  <= ~gnt1;
            k     <= 2'd0;
            state <= ADD;
          end
        end
        ADD: begin
          acc[{k, 2'b00} +: 4] <= s;
          carry <= c[4];
          k     <= k + 2'd1;
          if (k == 2'd3) begin
            sum     <= {s, acc[11:0]};
            cout    <= c[4];
            done_id <= owner;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cla_add_scheduler.md
CLA_ADD_SCHEDULER -- requirements
Module: cla_add_scheduler

Interface
REQ-001 The module SHALL have a single clock and a reset that is synchronous and active-low.
REQ-002 Parameters: none; the operand width SHALL be fixed at 16 bits, processed as four 4-bit nibbles.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 req0 / req1  input  1  requester 0 / 1 add request, level, held until granted.
REQ-006 a0, b0 / a1, b1  input  16  requester 0 / 1 operands.
REQ-007 cin0 / cin1  input  1  requester 0 / 1 carry-in.
REQ-008 gnt0 / gnt1  output  1  accept pulse; operands and carry-in of that requester are sampled on the clk edge ending this cycle.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 sum  output  16  registered result of the last completed add.
REQ-011 cout  output  1  registered carry-out of the last completed add.
REQ-012 done  output  1  one-cycle pulse when sum/cout are updated.
REQ-013 done_id  output  1  requester index (0/1) that owns the current sum/cout.

Function
REQ-014 States SHALL be IDLE, ADD, DONE, with a 2-bit nibble counter k used in ADD.
REQ-015 In IDLE, gnt0/gnt1 SHALL be combinational; at most one SHALL be high, and neither SHALL be high outside IDLE or while rst_n=0.
REQ-016 Arbitration SHALL be round-robin: a single request is granted; on a tie, the requester not granted last wins; after reset, requester 0 wins the first tie.
REQ-017 On a grant edge, the module SHALL latch A, B and Cin, record the owner, set k=0 and go IDLE->ADD.
REQ-018 Each ADD cycle SHALL compute nibble k with 4-bit carry-lookahead logic: gi=AiBi, pi=Ai^Bi, ci+1=gi+pi·ci expanded in sum-of-products form, si=pi^ci.
REQ-019 Carry into nibble 0 SHALL be the latched Cin; carry into nibble k>0 SHALL be the registered carry-out of nibble k-1.
REQ-020 After nibble 3 the state SHALL go ADD->DONE.
REQ-021 On the ADD->DONE edge, the module SHALL load sum, cout (carry-out of nibble 3) and done_id.
REQ-022 done SHALL be high for exactly the one DONE cycle, after which the state SHALL return to IDLE.
REQ-023 Latency: a grant in cycle T SHALL give done=1 in cycle T+5; the earliest next grant SHALL be in cycle T+6.
REQ-024 sum, cout and done_id SHALL hold their values until the next done.
REQ-025 Input changes after the grant edge (operands, cin, req) SHALL NOT affect the in-flight result.
REQ-026 A request that drops before its grant SHALL be discarded silently; requests seen in ADD or DONE SHALL wait and not be granted.
REQ-027 Arithmetic SHALL be unsigned modulo 2^16, with cout as the 17th bit; no overflow flag SHALL be produced.

Reset
REQ-028 While rst_n=0 at a clk edge: state=IDLE, k=0, sum=0x0000, cout=0, done=0, done_id=0, round-robin pointer=requester 0 last-loser, internal carry=0.
REQ-029 Reset during ADD or DONE SHALL abort the operation with no done pulse; the first grant after reset SHALL operate normally.

Verification
REQ-030 Reset: rst_n=0 for 2 cycles mid-ADD -> busy=0, done=0, sum=0x0000, cout=0, no done pulse afterwards.
REQ-031 Single add: req0, a0=0x1234, b0=0x4321, cin0=0 -> gnt0 in cycle T; done at T+5 with sum=0x5555, cout=0, done_id=0.
REQ-032 Full carry chain: req1, a1=0xFFFF, b1=0x0000, cin1=1 -> sum=0x0000, cout=1, done_id=1; a1=0x8000, b1=0x8000, cin1=0 -> sum=0x0000, cout=1.
REQ-033 Tie/fairness: req0 and req1 held high after reset -> grants alternate 0,1,0,1 at 6-cycle spacing, and each done_id matches its grant.
REQ-034 Busy and hold: req1 raised during an ADD of requester 0, and a0 changed after gnt0 -> gnt1 only in the cycle after done; requester 0's result uses the sampled operands.
REQ-035 Abort: rst_n=0 in the second ADD cycle of 0x00FF+0x0001 -> no done; the next request of 0x00FF+0x0001 gives sum=0x0100, cout=0.
